// File: rtl/bp_cce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_cce_pkg
// Description : Shared types and helpers for the CCE microcode loader.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_cce_pkg;

    localparam int c_bp_cce_inst_width = 48;

    typedef enum logic [3:0] {
        LS_IDLE    = 4'd0,
        LS_ROM_RD  = 4'd1,
        LS_ROM_CAP = 4'd2,
        LS_WR_LO   = 4'd3,
        LS_WR_HI   = 4'd4,
        LS_RD_LO   = 4'd5,
        LS_RESP_LO = 4'd6,
        LS_RD_HI   = 4'd7,
        LS_RESP_HI = 4'd8,
        LS_DONE    = 4'd9,
        LS_ERROR   = 4'd10
    } loader_state_e;

    // Config address layout: msb selects the instruction RAM, index sits
    // above bit 0, bit 0 picks the hi half. Caller truncates to addr_w bits.
    function automatic logic [63:0] pack_cfg_addr(
        input logic        ram_sel,
        input logic [31:0] index,
        input logic        hi,
        input int unsigned addr_w
    );
        logic [63:0] r;
        r            = {31'b0, index, hi};
        r[addr_w-1]  = ram_sel;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_cce_ucode_loader.sv
`default_nettype none
// ============================================================================
// Module      : bp_cce_ucode_loader
// Description : Streams a boot-ROM microcode image into the CCE instruction
//               RAM over the config link, optionally verifies it, then
//               releases the CCE freeze.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_cce_ucode_loader
    import bp_cce_pkg::*;
#(
    parameter int INST_RAM_ELS_P        = 256,
    parameter int NUM_INST_P            = 256,
    parameter int INST_WIDTH_P          = c_bp_cce_inst_width,
    parameter int CFG_LINK_ADDR_WIDTH_P = 16,
    parameter int CFG_LINK_DATA_WIDTH_P = 32,
    parameter int VERIFY_P              = 1
) (
    input  logic                                                   clk_i,
    input  logic                                                   reset_i,
    input  logic                                                   start_i,
    output logic                                                   rom_v_o,
    output logic [((NUM_INST_P > 1) ? $clog2(NUM_INST_P) : 1)-1:0] rom_addr_o,
    input  logic [INST_WIDTH_P-1:0]                                rom_data_i,
    output logic [CFG_LINK_ADDR_WIDTH_P-2:0]                       config_addr_o,
    output logic [CFG_LINK_DATA_WIDTH_P-1:0]                       config_data_o,
    output logic                                                   config_v_o,
    output logic                                                   config_w_o,
    input  logic                                                   config_ready_i,
    input  logic [CFG_LINK_DATA_WIDTH_P-1:0]                       config_data_i,
    input  logic                                                   config_v_i,
    output logic                                                   config_ready_o,
    output logic                                                   freeze_o,
    output logic                                                   done_o,
    output logic                                                   err_o
);

    localparam int c_idx_w  = (NUM_INST_P > 1) ? $clog2(NUM_INST_P) : 1;
    localparam int c_ram_iw = (INST_RAM_ELS_P > 1) ? $clog2(INST_RAM_ELS_P) : 1;
    localparam int c_addr_w = CFG_LINK_ADDR_WIDTH_P - 1;
    localparam int c_dw     = CFG_LINK_DATA_WIDTH_P;
    // Only the bits of the hi half that carry instruction content are compared.
    localparam logic [c_dw-1:0] c_hi_mask = {c_dw{1'b1}} >> (2*c_dw - INST_WIDTH_P);

    loader_state_e            r_state_q, w_state_d;
    logic [c_idx_w-1:0]       r_idx_q, w_idx_d;
    logic [INST_WIDTH_P-1:0]  r_inst_q, w_inst_d;
    logic [c_idx_w-1:0]       r_err_idx_q, w_err_idx_d;

    logic [c_dw-1:0]          w_lo_data;
    logic [c_dw-1:0]          w_hi_data;
    logic [c_ram_iw-1:0]      w_ram_index;
    logic [c_addr_w-1:0]      w_addr_lo;
    logic [c_addr_w-1:0]      w_addr_hi;
    logic                     w_is_last;

    assign w_lo_data   = r_inst_q[c_dw-1:0];
    assign w_hi_data   = c_dw'(r_inst_q[INST_WIDTH_P-1:c_dw]);
    assign w_ram_index = c_ram_iw'(r_idx_q);
    assign w_addr_lo   = c_addr_w'(pack_cfg_addr(1'b1, 32'(w_ram_index), 1'b0, c_addr_w));
    assign w_addr_hi   = c_addr_w'(pack_cfg_addr(1'b1, 32'(w_ram_index), 1'b1, c_addr_w));
    assign w_is_last   = (r_idx_q == c_idx_w'(NUM_INST_P - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state_q   <= LS_IDLE;
            r_idx_q     <= '0;
            r_inst_q    <= '0;
            r_err_idx_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_idx_q     <= w_idx_d;
            r_inst_q    <= w_inst_d;
            r_err_idx_q <= w_err_idx_d;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_idx_d     = r_idx_q;
        w_inst_d    = r_inst_q;
        w_err_idx_d = r_err_idx_q;

        case (r_state_q)
            LS_IDLE:    if (start_i) w_state_d = LS_ROM_RD;
            LS_ROM_RD:  w_state_d = LS_ROM_CAP;
            LS_ROM_CAP: begin
                w_inst_d  = rom_data_i;
                w_state_d = LS_WR_LO;
            end
            LS_WR_LO:   if (config_ready_i) w_state_d = LS_WR_HI;
            LS_WR_HI: begin
                if (config_ready_i) begin
                    if (VERIFY_P != 0) begin
                        w_state_d = LS_RD_LO;
                    end else if (w_is_last) begin
                        w_state_d = LS_DONE;
                    end else begin
                        w_idx_d   = r_idx_q + c_idx_w'(1);
                        w_state_d = LS_ROM_RD;
                    end
                end
            end
            LS_RD_LO:   if (config_ready_i) w_state_d = LS_RESP_LO;
            LS_RESP_LO: begin
                if (config_v_i) begin
                    if (config_data_i == w_lo_data) begin
                        w_state_d = LS_RD_HI;
                    end else begin
                        w_err_idx_d = r_idx_q;
                        w_state_d   = LS_ERROR;
                    end
                end
            end
            LS_RD_HI:   if (config_ready_i) w_state_d = LS_RESP_HI;
            LS_RESP_HI: begin
                if (config_v_i) begin
                    if ((config_data_i & c_hi_mask) != w_hi_data) begin
                        w_err_idx_d = r_idx_q;
                        w_state_d   = LS_ERROR;
                    end else if (w_is_last) begin
                        w_state_d = LS_DONE;
                    end else begin
                        w_idx_d   = r_idx_q + c_idx_w'(1);
                        w_state_d = LS_ROM_RD;
                    end
                end
            end
            LS_DONE:    w_state_d = LS_DONE;
            LS_ERROR:   w_state_d = LS_ERROR;
            default:    w_state_d = LS_IDLE;
        endcase
    end

    // Outputs decode purely from registered state, so a stalled request
    // holds address, data and valid steady until it is accepted.
    always_comb begin
        rom_v_o        = (r_state_q == LS_ROM_RD);
        rom_addr_o     = r_idx_q;
        config_v_o     = 1'b0;
        config_w_o     = 1'b0;
        config_addr_o  = '0;
        config_data_o  = '0;
        config_ready_o = (r_state_q == LS_RESP_LO) || (r_state_q == LS_RESP_HI);
        freeze_o       = (r_state_q != LS_DONE);
        done_o         = (r_state_q == LS_DONE);
        err_o          = (r_state_q == LS_ERROR);

        case (r_state_q)
            LS_WR_LO: begin
                config_v_o    = 1'b1;
                config_w_o    = 1'b1;
                config_addr_o = w_addr_lo;
                config_data_o = w_lo_data;
            end
            LS_WR_HI: begin
                config_v_o    = 1'b1;
                config_w_o    = 1'b1;
                config_addr_o = w_addr_hi;
                config_data_o = w_hi_data;
            end
            LS_RD_LO: begin
                config_v_o    = 1'b1;
                config_addr_o = w_addr_lo;
            end
            LS_RD_HI: begin
                config_v_o    = 1'b1;
                config_addr_o = w_addr_hi;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_cce_ucode_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_cce_ucode_loader
// Description : Scoreboard bench for the microcode loader; instance 0 runs
//               without read-back, instance 1 with read-back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_cce_ucode_loader;

    localparam int c_n  = 4;
    localparam int c_iw = 48;
    localparam int c_dw = 32;
    localparam int c_aw = 16;

    typedef struct {
        logic        w;
        logic [14:0] addr;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst[2];
    logic        start[2];
    logic        rom_v[2];
    logic [1:0]  rom_addr[2];
    logic [47:0] rom_data[2];
    logic [14:0] cfg_addr[2];
    logic [31:0] cfg_wdata[2];
    logic        cfg_v_o[2];
    logic        cfg_w[2];
    logic        cfg_rdy_i[2];
    logic [31:0] cfg_rdata[2];
    logic        cfg_v_i[2];
    logic        cfg_rdy_o[2];
    logic        freeze[2];
    logic        done[2];
    logic        err[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bp_cce_ucode_loader #(
            .INST_RAM_ELS_P       (256),
            .NUM_INST_P           (c_n),
            .INST_WIDTH_P         (c_iw),
            .CFG_LINK_ADDR_WIDTH_P(c_aw),
            .CFG_LINK_DATA_WIDTH_P(c_dw),
            .VERIFY_P             (g)
        ) u_dut (
            .clk_i         (clk),
            .reset_i       (rst[g]),
            .start_i       (start[g]),
            .rom_v_o       (rom_v[g]),
            .rom_addr_o    (rom_addr[g]),
            .rom_data_i    (rom_data[g]),
            .config_addr_o (cfg_addr[g]),
            .config_data_o (cfg_wdata[g]),
            .config_v_o    (cfg_v_o[g]),
            .config_w_o    (cfg_w[g]),
            .config_ready_i(cfg_rdy_i[g]),
            .config_data_i (cfg_rdata[g]),
            .config_v_i    (cfg_v_i[g]),
            .config_ready_o(cfg_rdy_o[g]),
            .freeze_o      (freeze[g]),
            .done_o        (done[g]),
            .err_o         (err[g])
        );
    end

    // Reference image and synchronous boot ROM (data one cycle after enable)
    logic [47:0] rom_img[2][c_n];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            if (rom_v[d]) rom_data[d] <= rom_img[d][rom_addr[d]];
    end

    beat_t       exp_q[2][$];
    resp_t       resp_q[2][$];
    logic [31:0] mem[2][512];
    logic        resp_take[2];
    int          n_beats[2];
    int          n_reads[2];
    int          stall_left[2];
    logic        stall_armed[2];
    logic [14:0] stall_addr[2];
    logic        spur_arm[2];
    logic        corrupt_en[2];
    logic        rand_rdy[2];
    logic [48:0] snap;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, got, want, $time);
        end
    endtask

    function automatic logic [14:0] exp_addr(input int i, input int hi);
        return 15'(16384 + 2*i + hi);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected request stream: per instruction, lo then hi write, and
    // (read-back instance only) lo then hi read, stopping after fail_idx.
    task automatic push_load(input int d, input int fail_idx);
        for (int i = 0; i < c_n; i++) begin
            exp_q[d].push_back('{1'b1, exp_addr(i, 0), rom_img[d][i][31:0]});
            exp_q[d].push_back('{1'b1, exp_addr(i, 1), {16'h0, rom_img[d][i][47:32]}});
            if (d == 1) begin
                exp_q[d].push_back('{1'b0, exp_addr(i, 0), 32'h0});
                exp_q[d].push_back('{1'b0, exp_addr(i, 1), 32'h0});
            end
            if (i == fail_idx) break;
        end
    endtask

    task automatic fill_rom(input int d);
        for (int i = 0; i < c_n; i++) rom_img[d][i] = {16'($urandom), 32'($urandom)};
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        exp_q[d].delete();
        resp_q[d].delete();
        resp_take[d] = 1'b0;
        n_beats[d]   = 0;
        n_reads[d]   = 0;
        tick();
        tick();
        rst[d] = 1'b0;
    endtask

    task automatic pulse_start(input int d, output int t0);
        start[d] = 1'b1;
        t0 = cyc + 1;
        tick();
        start[d] = 1'b0;
    endtask

    task automatic wait_end(input int d, input int bound, output int t_end, output logic fz_prev);
        logic hit;
        hit     = 1'b0;
        fz_prev = freeze[d];
        t_end   = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done[d] || err[d]) begin
                hit   = 1'b1;
                t_end = cyc;
                break;
            end
            fz_prev = freeze[d];
        end
        chk($sformatf("timeout_dut%0d", d), hit, 1'b1);
    endtask

    // Monitor: consumes accepted request beats against the expected queue.
    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst[d]) begin
                    if (cfg_v_o[d] && cfg_rdy_i[d]) begin
                        n_beats[d]++;
                        if (exp_q[d].size() == 0) begin
                            chk($sformatf("unexpected_beat_dut%0d", d), {cfg_w[d], cfg_addr[d]}, 64'h0);
                        end else begin
                            beat_t e;
                            e = exp_q[d].pop_front();
                            chk($sformatf("beat_w_dut%0d", d), cfg_w[d], e.w);
                            chk($sformatf("beat_addr_dut%0d", d), cfg_addr[d], e.addr);
                            if (e.w) begin
                                chk($sformatf("beat_data_dut%0d", d), cfg_wdata[d], e.data);
                                mem[d][cfg_addr[d][8:0]] = cfg_wdata[d];
                            end else begin
                                logic [31:0] rd;
                                n_reads[d]++;
                                rd = mem[d][cfg_addr[d][8:0]];
                                if (corrupt_en[d] && cfg_addr[d] == exp_addr(1, 1)) rd = rd ^ 32'h8;
                                resp_q[d].push_back('{rd, cyc + 3});
                            end
                        end
                    end
                    if (cfg_v_i[d] && cfg_rdy_o[d] && resp_q[d].size() > 0) resp_take[d] = 1'b1;
                end
            end
        end
    endtask

    // Link driver: ready (with optional stall / random backpressure) and
    // read responses with a fixed latency; spurious responses on request.
    task automatic driver();
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (resp_take[d]) begin
                    if (resp_q[d].size() > 0) void'(resp_q[d].pop_front());
                    resp_take[d] = 1'b0;
                end
                cfg_v_i[d]   = 1'b0;
                cfg_rdata[d] = 32'h0;
                if (resp_q[d].size() > 0 && resp_q[d][0].due <= cyc) begin
                    cfg_v_i[d]   = 1'b1;
                    cfg_rdata[d] = resp_q[d][0].data;
                end else if (spur_arm[d] && cfg_v_o[d] && cfg_w[d] && cfg_addr[d] == exp_addr(1, 0)) begin
                    cfg_v_i[d]   = 1'b1;
                    cfg_rdata[d] = 32'hDEAD_BEEF;
                    spur_arm[d]  = 1'b0;
                    #1;
                    chk($sformatf("spur_ready_o_dut%0d", d), cfg_rdy_o[d], 1'b0);
                end
                cfg_rdy_i[d] = rand_rdy[d] ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (stall_armed[d] && cfg_v_o[d] && cfg_w[d] && cfg_addr[d] == stall_addr[d]) begin
                    if (stall_left[d] == 5) begin
                        snap = {cfg_v_o[d], cfg_addr[d], cfg_wdata[d]};
                    end else begin
                        chk($sformatf("stall_stable_dut%0d", d), {cfg_v_o[d], cfg_addr[d], cfg_wdata[d]}, snap);
                    end
                    if (stall_left[d] > 0) begin
                        stall_left[d]--;
                        cfg_rdy_i[d] = 1'b0;
                    end else begin
                        stall_armed[d] = 1'b0;
                        cfg_rdy_i[d]   = 1'b1;
                    end
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int   t0, t_end;
        logic fz_prev, found;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;  start[d] = 1'b0;  cfg_rdy_i[d] = 1'b1;
            cfg_v_i[d] = 1'b0;  cfg_rdata[d] = 32'h0;  resp_take[d] = 1'b0;
            stall_left[d] = 0;  stall_armed[d] = 1'b0;  stall_addr[d] = 15'h0;
            spur_arm[d] = 1'b0;  corrupt_en[d] = 1'b0;  rand_rdy[d] = 1'b0;
            n_beats[d] = 0;  n_reads[d] = 0;
            for (int i = 0; i < c_n; i++) rom_img[d][i] = 48'h0;
            for (int i = 0; i < 512; i++) mem[d][i] = 32'h0;
        end
        snap = '0;
        fork
            monitor();
            driver();
        join_none

        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_freeze_dut%0d", d), freeze[d], 1'b1);
            chk($sformatf("rst_done_dut%0d", d), done[d], 1'b0);
            chk($sformatf("rst_err_dut%0d", d), err[d], 1'b0);
            chk($sformatf("rst_cfg_v_dut%0d", d), cfg_v_o[d], 1'b0);
            chk($sformatf("rst_rom_v_dut%0d", d), rom_v[d], 1'b0);
            chk($sformatf("rst_rdy_o_dut%0d", d), cfg_rdy_o[d], 1'b0);
        end

        // Fixed image, no read-back, ready always high: minimum latency
        do_reset(0);
        for (int i = 0; i < c_n; i++) rom_img[0][i] = 48'hA000_0000_0000 + 48'(i);
        push_load(0, -1);
        pulse_start(0, t0);
        wait_end(0, 200, t_end, fz_prev);
        chk("t1_done_latency", 64'(t_end - t0), 64'd16);
        chk("t1_done", done[0], 1'b1);
        chk("t1_freeze_low", freeze[0], 1'b0);
        chk("t1_freeze_before", fz_prev, 1'b1);
        chk("t1_queue_empty", 64'(exp_q[0].size()), 64'd0);
        chk("t1_beats", 64'(n_beats[0]), 64'd8);
        repeat (3) tick();
        chk("t1_done_sticky", done[0], 1'b1);

        // Stall on hi write of idx 2 and a spurious response during lo write
        do_reset(0);
        fill_rom(0);
        stall_addr[0]  = exp_addr(2, 1);
        stall_left[0]  = 5;
        stall_armed[0] = 1'b1;
        spur_arm[0]    = 1'b1;
        push_load(0, -1);
        pulse_start(0, t0);
        wait_end(0, 300, t_end, fz_prev);
        chk("t2_done", done[0], 1'b1);
        chk("t2_stall_consumed", {stall_armed[0], 32'(stall_left[0])}, 64'h0);
        chk("t2_spur_issued", spur_arm[0], 1'b0);
        chk("t2_queue_empty", 64'(exp_q[0].size()), 64'd0);
        chk("t2_beats", 64'(n_beats[0]), 64'd8);

        // Asynchronous reset while the lo write of idx 3 is pending
        do_reset(0);
        fill_rom(0);
        push_load(0, -1);
        pulse_start(0, t0);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (cfg_v_o[0] && cfg_w[0] && cfg_addr[0] == exp_addr(3, 0)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t3_reach_lo3", found, 1'b1);
        rst[0] = 1'b1;
        #1;
        chk("t3_abort_v", cfg_v_o[0], 1'b0);
        chk("t3_abort_addr_data", {cfg_addr[0], cfg_wdata[0]}, 64'h0);
        chk("t3_abort_freeze", freeze[0], 1'b1);
        chk("t3_pending", 64'(exp_q[0].size()), 64'd2);
        do_reset(0);
        push_load(0, -1);
        pulse_start(0, t0);
        wait_end(0, 200, t_end, fz_prev);
        chk("t3_restart_done", done[0], 1'b1);
        chk("t3_restart_beats", 64'(n_beats[0]), 64'd8);
        chk("t3_queue_empty", 64'(exp_q[0].size()), 64'd0);

        // Read-back, ready high then random backpressure
        for (int pass = 0; pass < 2; pass++) begin
            do_reset(1);
            fill_rom(1);
            rand_rdy[1] = (pass == 1);
            push_load(1, -1);
            pulse_start(1, t0);
            wait_end(1, 600, t_end, fz_prev);
            chk($sformatf("t4_done_p%0d", pass), done[1], 1'b1);
            chk($sformatf("t4_err_p%0d", pass), err[1], 1'b0);
            chk($sformatf("t4_reads_p%0d", pass), 64'(n_reads[1]), 64'd8);
            chk($sformatf("t4_queue_empty_p%0d", pass), 64'(exp_q[1].size()), 64'd0);
        end
        rand_rdy[1] = 1'b0;

        // Corrupted hi read-back at idx 1
        do_reset(1);
        fill_rom(1);
        corrupt_en[1] = 1'b1;
        push_load(1, 1);
        pulse_start(1, t0);
        wait_end(1, 300, t_end, fz_prev);
        chk("t5_err", err[1], 1'b1);
        chk("t5_done", done[1], 1'b0);
        chk("t5_freeze", freeze[1], 1'b1);
        chk("t5_err_idx", 64'(g_dut[1].u_dut.r_err_idx_q), 64'd1);
        repeat (20) tick();
        chk("t5_err_sticky", err[1], 1'b1);
        chk("t5_no_more_beats", 64'(n_beats[1]), 64'd8);
        chk("t5_queue_empty", 64'(exp_q[1].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
